mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data/address width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned
- ReadData  out  32  extended load data, sampled by the MEM/WB register
- StallMem  out  1  freeze IF..MEM stages
- FaultM  out  1  one-cycle misaligned/illegal-size flag
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] = 00
- mem_wdata  out  32  lane-aligned store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-004 In IDLE, an access (MemReadM|MemWriteM) that is aligned and legal SHALL latch the address, size, type and data, move to REQ, and drive StallMem=1 combinationally in that same cycle.
REQ-005 When both MemReadM and MemWriteM are high, the access SHALL be treated as a read.
REQ-006 An access is faulting when any of the following holds:
- Funct3M is in {011, 110, 111}
- a store uses Funct3M 100 or 101
- a halfword access has addr[0]=1
- a word access has addr[1:0]≠00
REQ-007 A faulting access SHALL produce FaultM=1 for that cycle, StallMem=0, no request, an unchanged ReadData, and the FSM SHALL remain in IDLE.
REQ-008 In REQ, mem_req SHALL be 1 and mem_addr/mem_we/mem_be/mem_wdata SHALL be held stable until mem_gnt=1.
REQ-009 On mem_gnt, a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-010 In WAIT, mem_req SHALL be 0; mem_rvalid=1 SHALL capture the extracted and extended data into ReadData and move to DONE.
REQ-011 mem_rvalid in IDLE, REQ or DONE SHALL be ignored.
REQ-012 In DONE, StallMem SHALL be 0 for exactly one cycle and ReadData SHALL be valid; the FSM SHALL then return to IDLE unconditionally, without re-triggering on the same instruction.
REQ-013 StallMem SHALL be 1 in REQ and WAIT, and in IDLE when a legal access is present; otherwise it SHALL be 0.
REQ-014 Minimum load latency SHALL be 4 cycles (IDLE, REQ with gnt, WAIT with rvalid, DONE); minimum store latency SHALL be 3 cycles; there is no timeout.
REQ-015 Store lanes, with off = addr[1:0]:
- byte: mem_be = 0001<<off, mem_wdata = byte replicated ×4
- half: mem_be = 0011<<off, mem_wdata = half replicated ×2
- word: mem_be = 1111, mem_wdata = WriteDataM
REQ-016 Reads SHALL drive mem_be=1111 and mem_we=0.
REQ-017 Load extraction SHALL select the byte or half at the latched offset; B/H SHALL sign-extend, BU/HU SHALL zero-extend, and W SHALL pass the word through.
REQ-018 ReadData SHALL change only on a capture in WAIT.
REQ-019 Outside REQ, mem_req SHALL be 0; mem_addr, mem_be and mem_wdata are don't-care outside REQ.

Reset
REQ-020 While rst=1, the block SHALL asynchronously force the following, from any state:
- FSM to IDLE
- mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0
- ReadData=0, StallMem=0, FaultM=0
REQ-021 Reset in REQ or WAIT SHALL abandon the access, and a later mem_rvalid for it SHALL be ignored.

Verification
REQ-022 Load byte: LB at 0x103, mem_rdata=0x80FF_1234, gnt after 1 wait cycle, rvalid 2 cycles later:
- mem_addr=0x100
- ReadData=0xFFFF_FF80 in DONE
- StallMem high until DONE
REQ-023 Load half, unsigned: LHU at 0x202, mem_rdata=0xBEEF_0000, immediate gnt/rvalid -> ReadData=0x0000_BEEF, 4-cycle latency.
REQ-024 Store byte: SB 0xAB at 0x301 with immediate gnt:
- mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB, mem_addr=0x300
- DONE on the next cycle, ReadData unchanged
REQ-025 Faulting accesses:
- LW at 0x402 -> FaultM=1 one cycle, mem_req stays 0, StallMem=0
- Funct3M=011 with MemReadM=1 -> same response
REQ-026 Reset mid-operation: rst asserted in WAIT, then mem_rvalid after release -> state IDLE, ReadData=0, no DONE cycle.
REQ-027 Back-to-back: LW at 0x10 then SW at 0x14 -> two complete handshakes, each instruction issued exactly once, DONE cycles separated by ≥1 IDLE cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: lane-aligns stores, extracts/extends loads and
// stalls IF..MEM across the gnt/rvalid handshake with the data memory.
module mem_access_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            Funct3M,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  StallMem,
   output logic                  FaultM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                state;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic                  rd_q;
   logic                  access;
   logic                  bad_f3;
   logic                  bad_align;
   logic                  fault;
   logic [1:0]            off;
   logic [3:0]            be_n;
   logic [DATA_WIDTH-1:0] wdata_n;
   logic [DATA_WIDTH-1:0] byte_sh;
   logic [DATA_WIDTH-1:0] half_sh;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] load_ext;

   // A simultaneous read+write is a read, so unsigned sizes are only illegal for pure stores.
   always_comb begin
      access    = MemReadM | MemWriteM;
      off       = ALUResultM[1:0];
      bad_f3    = (Funct3M == 3'b011) || (Funct3M[2:1] == 2'b11) || (!MemReadM && Funct3M[2]);
      bad_align = ((Funct3M[1:0] == 2'b01) && off[0]) ||
                  ((Funct3M[1:0] == 2'b10) && (off != 2'b00));
      fault     = access && (bad_f3 || bad_align);
      FaultM    = !rst && (state == IDLE) && fault;
      StallMem  = !rst && ((state == REQ) || (state == WAIT) ||
                           ((state == IDLE) && access && !fault));
   end

   always_comb begin
      be_n    = 4'b1111;
      wdata_n = WriteDataM;
      if (!MemReadM) begin
         case (Funct3M[1:0])
            2'b00: begin
               be_n    = 4'b0001 << off;
               wdata_n = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               be_n    = 4'b0011 << off;
               wdata_n = {2{WriteDataM[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      byte_sh = mem_rdata >> {off_q, 3'b000};
      half_sh = mem_rdata >> {off_q[1], 4'b0000};
      ld_byte = byte_sh[7:0];
      ld_half = half_sh[15:0];
      case (f3_q)
         3'b000:  load_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
         3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
         3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'b0000;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ReadData  <= '0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         rd_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (access && !fault) begin
                  state     <= REQ;
                  mem_req   <= 1'b1;
                  mem_we    <= !MemReadM;
                  mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                  mem_be    <= be_n;
                  mem_wdata <= wdata_n;
                  f3_q      <= Funct3M;
                  off_q     <= off;
                  rd_q      <= MemReadM;
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= rd_q ? WAIT : DONE;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  ReadData <= load_ext;
                  state    <= DONE;
               end
            end
            // The pipeline advances this cycle, so the held instruction must not restart.
            DONE: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic [31:0] ReadData;
   logic        StallMem, FaultM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadData(ReadData), .StallMem(StallMem), .FaultM(FaultM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_exp_t;

   typedef struct {
      logic [31:0] rdata;
      int          stall;
   } done_exp_t;

   req_exp_t  req_q[$];
   done_exp_t done_q[$];
   int        checks = 0;
   int        errors = 0;
   int        handshakes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // Request monitor: every cycle with mem_req is compared against the head expectation.
   req_exp_t re;
   always @(negedge clk) begin
      if (!rst && mem_req) begin
         if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got request to 0x%08h, required none", mem_addr);
         end else begin
            re = req_q[0];
            check("req_addr", mem_addr, re.addr);
            check("req_we", {31'b0, mem_we}, {31'b0, re.we});
            check("req_be", {28'b0, mem_be}, {28'b0, re.be});
            if (re.we) check("req_wdata", mem_wdata, re.wdata);
            if (mem_gnt) begin
               void'(req_q.pop_front());
               handshakes++;
            end
         end
      end
   end

   // Completion monitor: the DONE cycle is the first unstalled cycle after a stall run.
   logic      prev_stall = 1'b0;
   int        stall_run = 0;
   done_exp_t de;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         stall_run  = 0;
      end else begin
         if (StallMem) stall_run++;
         else if (prev_stall) begin
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got completion with ReadData 0x%08h, required none", ReadData);
            end else begin
               de = done_q.pop_front();
               check("done_rdata", ReadData, de.rdata);
               check("stall_cycles", stall_run, de.stall);
            end
            stall_run = 0;
         end
         prev_stall = StallMem;
      end
   end

   task automatic set_instr(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
      MemReadM   = rd;
      MemWriteM  = wr;
      Funct3M    = f3;
      ALUResultM = addr;
      WriteDataM = wdata;
   endtask

   // Issues one legal access; gnt after gnt_dly stalled REQ cycles, rvalid after rv_dly empty WAIT cycles.
   task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                         input req_exp_t rexp, input logic [31:0] exp_rd);
      done_exp_t d;
      @(posedge clk); #1;
      set_instr(rd, wr, f3, addr, wdata);
      req_q.push_back(rexp);
      d.rdata = exp_rd;
      d.stall = rd ? 3 + gnt_dly + rv_dly : 2 + gnt_dly;
      done_q.push_back(d);
      @(posedge clk); #1;
      repeat (gnt_dly) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'h5A5A_5A5A;
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (rd) begin
         repeat (rv_dly) begin @(posedge clk); #1; end
         mem_rdata  = rdata;
         mem_rvalid = 1'b1;
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         mem_rdata  = 32'h0;
      end
   endtask

   task automatic fault_op(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] exp_rd);
      @(posedge clk); #1;
      set_instr(rd, wr, f3, addr, 32'hFFFF_FFFF);
      #1;
      check("fault_flag", {31'b0, FaultM}, 32'd1);
      check("fault_stall", {31'b0, StallMem}, 32'd0);
      check("fault_req", {31'b0, mem_req}, 32'd0);
      @(posedge clk); #1;
      set_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      check("fault_no_req_after", {31'b0, mem_req}, 32'd0);
      check("fault_rdata_kept", ReadData, exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      set_instr(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", ReadData, 32'h0);
      check("rst_stall", {31'b0, StallMem}, 32'd0);
      check("rst_fault", {31'b0, FaultM}, 32'd0);
      check("rst_req", {31'b0, mem_req}, 32'd0);
      check("rst_we", {31'b0, mem_we}, 32'd0);
      check("rst_be", {28'b0, mem_be}, 32'd0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      set_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      mem_op(1, 0, 3'b000, 32'h103, 32'h0, 1, 1, 32'h80FF_1234,
             req_exp_t'{32'h100, 1'b0, 4'hF, 32'h0}, 32'hFFFF_FF80);
      mem_op(1, 0, 3'b101, 32'h202, 32'h0, 0, 0, 32'hBEEF_0000,
             req_exp_t'{32'h200, 1'b0, 4'hF, 32'h0}, 32'h0000_BEEF);
      mem_op(0, 1, 3'b000, 32'h301, 32'h1234_56AB, 0, 0, 32'h0,
             req_exp_t'{32'h300, 1'b1, 4'b0010, 32'hABAB_ABAB}, 32'h0000_BEEF);
      mem_op(0, 1, 3'b001, 32'h002, 32'h9999_CAFE, 2, 0, 32'h0,
             req_exp_t'{32'h000, 1'b1, 4'b1100, 32'hCAFE_CAFE}, 32'h0000_BEEF);
      mem_op(1, 0, 3'b001, 32'h006, 32'h0, 0, 1, 32'h8001_7FFF,
             req_exp_t'{32'h004, 1'b0, 4'hF, 32'h0}, 32'hFFFF_8001);
      mem_op(1, 0, 3'b100, 32'h102, 32'h0, 0, 0, 32'h80FF_1234,
             req_exp_t'{32'h100, 1'b0, 4'hF, 32'h0}, 32'h0000_00FF);

      fault_op(1, 0, 3'b010, 32'h402, 32'h0000_00FF);
      fault_op(1, 0, 3'b011, 32'h000, 32'h0000_00FF);
      fault_op(0, 1, 3'b100, 32'h008, 32'h0000_00FF);
      fault_op(1, 0, 3'b001, 32'h003, 32'h0000_00FF);
      fault_op(0, 1, 3'b010, 32'h041, 32'h0000_00FF);

      mem_op(1, 1, 3'b100, 32'h103, 32'hFFFF_FFFF, 0, 0, 32'h80FF_1234,
             req_exp_t'{32'h100, 1'b0, 4'hF, 32'h0}, 32'h0000_0080);
      mem_op(1, 0, 3'b010, 32'h010, 32'h0, 0, 0, 32'hDEAD_BEEF,
             req_exp_t'{32'h010, 1'b0, 4'hF, 32'h0}, 32'hDEAD_BEEF);
      mem_op(0, 1, 3'b010, 32'h014, 32'h0123_4567, 1, 0, 32'h0,
             req_exp_t'{32'h014, 1'b1, 4'hF, 32'h0123_4567}, 32'hDEAD_BEEF);

      // Reset while waiting for read data; the late rvalid must be dropped.
      @(posedge clk); #1;
      set_instr(1'b1, 1'b0, 3'b010, 32'h020, 32'h0);
      req_q.push_back(req_exp_t'{32'h020, 1'b0, 4'hF, 32'h0});
      @(posedge clk); #1;
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_stall", {31'b0, StallMem}, 32'd0);
      check("midrst_req", {31'b0, mem_req}, 32'd0);
      check("midrst_rdata", ReadData, 32'h0);
      check("midrst_be", {28'b0, mem_be}, 32'd0);
      check("midrst_fault", {31'b0, FaultM}, 32'd0);
      set_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      mem_rdata  = 32'h5555_5555;
      mem_rvalid = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      #1;
      check("postrst_rdata", ReadData, 32'h0);
      check("postrst_stall", {31'b0, StallMem}, 32'd0);
      check("postrst_req", {31'b0, mem_req}, 32'd0);
      repeat (3) @(posedge clk);
      #1;

      check("req_q_drained", req_q.size(), 32'd0);
      check("done_q_drained", done_q.size(), 32'd0);
      check("handshake_count", handshakes, 32'd10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
